vram_arbiter: RTL and testbench

- Shares the single-port video memory between two requesters: the CPU's WVM write path and the VGA scan-out reader.
- VGA reads have priority. CPU writes are buffered in a small FIFO and drained into free RAM cycles.
- A starvation counter forces a CPU write slot when the VGA side holds the RAM for too long.
- Sits between the CPU execute stage, the VGA controller and the video RAM.

---
 rtl/vram_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single-port video RAM between the VGA scan-out reader and the
// CPU's WVM write path. VGA reads win by default; CPU writes are buffered in
// a small FIFO and drained into cycles the VGA side leaves free. A starvation
// counter forces a write slot if the VGA side holds the RAM too long.
//
// Ports:
//   Clock       - system clock, rising edge
//   Reset       - asynchronous, active-low reset
//   iCpuWe      - one-cycle CPU write request
//   iCpuAddr    - CPU write address
//   iCpuData    - CPU write colour
//   oCpuStall   - write FIFO full, CPU must hold off
//   oWriteIdle  - FIFO empty and no write currently driven to the RAM
//   oOverflow   - sticky flag: a write arrived while the FIFO was full
//   iVgaReq     - VGA pixel read request (sampled every cycle)
//   iVgaAddr    - VGA read address
//   oVgaData    - pixel returned to the VGA side
//   oVgaValid   - oVgaData valid this cycle (two cycles after the request)
//   oRamAddr    - registered RAM address
//   oRamData    - registered RAM write data
//   oRamWe      - registered RAM write enable
//   iRamData    - synchronous RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 3,
    parameter int FIFO_DEPTH   = 4,   // power of two, at least 2
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCpuWe,
    input  logic [ADDR_WIDTH-1:0] iCpuAddr,
    input  logic [DATA_WIDTH-1:0] iCpuData,
    output logic                  oCpuStall,
    output logic                  oWriteIdle,
    output logic                  oOverflow,
    input  logic                  iVgaReq,
    input  logic [ADDR_WIDTH-1:0] iVgaAddr,
    output logic [DATA_WIDTH-1:0] oVgaData,
    output logic                  oVgaValid,
    output logic [ADDR_WIDTH-1:0] oRamAddr,
    output logic [DATA_WIDTH-1:0] oRamData,
    output logic                  oRamWe,
    input  logic [DATA_WIDTH-1:0] iRamData
);

    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_READ,
        GRANT_WRITE
    } grant_e;

    // Write buffer storage; validity is tracked by the pointers and count
    logic [ADDR_WIDTH-1:0] fifoAddr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifoData_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q,    rdPtr_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic [STARVE_W-1:0]   starve_q,   starve_d;
    logic                  stall_q,    stall_d;
    logic                  overflow_q, overflow_d;
    logic [ADDR_WIDTH-1:0] ramAddr_q,  ramAddr_d;
    logic [DATA_WIDTH-1:0] ramData_q,  ramData_d;
    logic                  ramWe_q,    ramWe_d;
    logic                  rdPend_q,   rdPend_d;
    logic                  vgaValid_q, vgaValid_d;
    logic [DATA_WIDTH-1:0] vgaData_q,  vgaData_d;

    logic   fifoEmpty;
    logic   fifoFull;
    logic   push;
    logic   pop;
    logic   forceWrite;
    grant_e grant;

    // Arbitration and next-state logic. All decisions use the count as it
    // stood at the start of the cycle, so a write pushed into an empty FIFO
    // only becomes eligible for a grant in the following cycle.
    always_comb begin
        fifoEmpty  = (count_q == '0);
        fifoFull   = (count_q == FULL_COUNT);
        push       = iCpuWe && !fifoFull;
        forceWrite = !fifoEmpty && (starve_q == STARVE_MAX);

        grant = GRANT_IDLE;
        if (forceWrite) begin
            grant = GRANT_WRITE;
        end else if (iVgaReq) begin
            grant = GRANT_READ;
        end else if (!fifoEmpty) begin
            grant = GRANT_WRITE;
        end

        pop = (grant == GRANT_WRITE);

        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        overflow_d = overflow_q;
        ramAddr_d  = ramAddr_q;
        ramData_d  = ramData_q;
        ramWe_d    = 1'b0;
        rdPend_d   = 1'b0;

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        stall_d = (count_d == FULL_COUNT);

        if (iCpuWe && fifoFull) begin
            overflow_d = 1'b1;
        end

        // Counts cycles a queued write was passed over; saturates so the
        // force condition stays asserted until a write is actually granted.
        if (fifoEmpty || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        case (grant)
            GRANT_READ: begin
                ramAddr_d = iVgaAddr;
                rdPend_d  = 1'b1;
            end
            GRANT_WRITE: begin
                ramAddr_d = fifoAddr_q[rdPtr_q];
                ramData_d = fifoData_q[rdPtr_q];
                ramWe_d   = 1'b1;
            end
            default: begin
            end
        endcase

        // The RAM answers one cycle after the address, so a read issued at
        // edge N+1 is reported during N+2. The last pixel is held so the
        // data output stays steady between reads.
        vgaValid_d = rdPend_q;
        vgaData_d  = vgaValid_q ? iRamData : vgaData_q;
    end

    // FIFO storage is not reset: the cleared count already marks it empty
    always_ff @(posedge Clock) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= iCpuAddr;
            fifoData_q[wrPtr_q] <= iCpuData;
        end
    end

    // Control and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            ramAddr_q  <= '0;
            ramData_q  <= '0;
            ramWe_q    <= 1'b0;
            rdPend_q   <= 1'b0;
            vgaValid_q <= 1'b0;
            vgaData_q  <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            ramAddr_q  <= ramAddr_d;
            ramData_q  <= ramData_d;
            ramWe_q    <= ramWe_d;
            rdPend_q   <= rdPend_d;
            vgaValid_q <= vgaValid_d;
            vgaData_q  <= vgaData_d;
        end
    end

    assign oCpuStall  = stall_q;
    assign oOverflow  = overflow_q;
    assign oWriteIdle = fifoEmpty && !ramWe_q;
    assign oRamAddr   = ramAddr_q;
    assign oRamData   = ramData_q;
    assign oRamWe     = ramWe_q;
    assign oVgaValid  = vgaValid_q;
    assign oVgaData   = vgaValid_q ? iRamData : vgaData_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed testbench for vram_arbiter with a small synchronous RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int AW = 16;
    localparam int DW = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iCpuWe;
    logic [AW-1:0] iCpuAddr;
    logic [DW-1:0] iCpuData;
    logic          oCpuStall;
    logic          oWriteIdle;
    logic          oOverflow;
    logic          iVgaReq;
    logic [AW-1:0] iVgaAddr;
    logic [DW-1:0] oVgaData;
    logic          oVgaValid;
    logic [AW-1:0] oRamAddr;
    logic [DW-1:0] oRamData;
    logic          oRamWe;
    logic [DW-1:0] iRamData;

    int checks = 0;
    int errors = 0;

    // Log of every RAM write seen while out of reset
    logic [AW-1:0] logAddr [64];
    logic [DW-1:0] logData [64];
    int            wrCount = 0;

    vram_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (4),
        .STARVE_LIMIT(64)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iCpuWe    (iCpuWe),
        .iCpuAddr  (iCpuAddr),
        .iCpuData  (iCpuData),
        .oCpuStall (oCpuStall),
        .oWriteIdle(oWriteIdle),
        .oOverflow (oOverflow),
        .iVgaReq   (iVgaReq),
        .iVgaAddr  (iVgaAddr),
        .oVgaData  (oVgaData),
        .oVgaValid (oVgaValid),
        .oRamAddr  (oRamAddr),
        .oRamData  (oRamData),
        .oRamWe    (oRamWe),
        .iRamData  (iRamData)
    );

    always #5 Clock = ~Clock;

    // Read-only RAM contents: 0x0010 holds 3'b010, all others the low address bits
    function automatic logic [DW-1:0] ramContent(input logic [AW-1:0] a);
        if (a == 16'h0010) return 3'b010;
        return a[DW-1:0];
    endfunction

    // Synchronous RAM read port: data appears one cycle after the address
    logic [DW-1:0] ramRd = '0;
    always @(posedge Clock) ramRd <= ramContent(oRamAddr);
    assign iRamData = ramRd;

    // Record write pulses as they appear on the RAM port
    always @(negedge Clock) begin
        if (Reset && oRamWe) begin
            logAddr[wrCount % 64] = oRamAddr;
            logData[wrCount % 64] = oRamData;
            wrCount = wrCount + 1;
        end
    end

    // Single comparison point used by every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge
    task automatic applyStimulus(input logic we, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                 input logic vr, input logic [AW-1:0] va);
        @(negedge Clock);
        iCpuWe   = we;
        iCpuAddr = ca;
        iCpuData = cd;
        iVgaReq  = vr;
        iVgaAddr = va;
    endtask

    // Hard time limit so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    int  base;
    int  firstWe;
    int  weTotal;
    logic validAt [100];

    initial begin
        Reset    = 1'b0;
        iCpuWe   = 1'b0;
        iCpuAddr = '0;
        iCpuData = '0;
        iVgaReq  = 1'b0;
        iVgaAddr = '0;

        // Reset values while reset is held
        repeat (3) @(negedge Clock);
        checkOutput("rst_ramAddr",  32'(oRamAddr),  32'h0);
        checkOutput("rst_ramData",  32'(oRamData),  32'h0);
        checkOutput("rst_ramWe",    32'(oRamWe),    32'h0);
        checkOutput("rst_vgaValid", 32'(oVgaValid), 32'h0);
        checkOutput("rst_vgaData",  32'(oVgaData),  32'h0);
        checkOutput("rst_overflow", 32'(oOverflow), 32'h0);
        checkOutput("rst_stall",    32'(oCpuStall), 32'h0);
        checkOutput("rst_idle",     32'(oWriteIdle), 32'h1);
        Reset = 1'b1;

        // Quiet after release
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            checkOutput("quiet_we",    32'(oRamWe),     32'h0);
            checkOutput("quiet_valid", 32'(oVgaValid),  32'h0);
            checkOutput("quiet_idle",  32'(oWriteIdle), 32'h1);
            checkOutput("quiet_stall", 32'(oCpuStall),  32'h0);
        end

        // Single VGA read of 0x0010
        applyStimulus(1'b0, '0, '0, 1'b1, 16'h0010);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        checkOutput("rd_addr_n1",  32'(oRamAddr),  32'h0010);
        checkOutput("rd_we_n1",    32'(oRamWe),    32'h0);
        checkOutput("rd_valid_n1", 32'(oVgaValid), 32'h0);
        @(negedge Clock);
        checkOutput("rd_valid_n2", 32'(oVgaValid), 32'h1);
        checkOutput("rd_data_n2",  32'(oVgaData),  32'h2);
        @(negedge Clock);
        checkOutput("rd_valid_n3", 32'(oVgaValid), 32'h0);

        // Four CPU writes with no VGA traffic drain in order
        #1 base = wrCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, AW'(i), DW'(i + 1), 1'b0, '0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        repeat (6) @(negedge Clock);
        #1;
        checkOutput("wr_count", 32'(wrCount - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("wr_addr", 32'(logAddr[(base + i) % 64]), 32'(i));
            checkOutput("wr_data", 32'(logData[(base + i) % 64]), 32'(i + 1));
        end
        checkOutput("wr_idle",     32'(oWriteIdle), 32'h1);
        checkOutput("wr_overflow", 32'(oOverflow),  32'h0);

        // Fill the FIFO behind continuous reads; the fifth write is dropped
        base = wrCount;
        applyStimulus(1'b1, 16'h0020, 3'd1, 1'b1, 16'h0010);
        applyStimulus(1'b1, 16'h0021, 3'd2, 1'b1, 16'h0010);
        checkOutput("full_stall1", 32'(oCpuStall), 32'h0);
        applyStimulus(1'b1, 16'h0022, 3'd3, 1'b1, 16'h0010);
        checkOutput("full_stall2", 32'(oCpuStall), 32'h0);
        applyStimulus(1'b1, 16'h0023, 3'd4, 1'b1, 16'h0010);
        checkOutput("full_stall3", 32'(oCpuStall), 32'h0);
        applyStimulus(1'b1, 16'h0024, 3'd5, 1'b1, 16'h0010);
        checkOutput("full_stall4", 32'(oCpuStall), 32'h1);
        checkOutput("full_ovf_pre", 32'(oOverflow), 32'h0);
        checkOutput("full_nowrite", 32'(oRamWe),    32'h0);
        applyStimulus(1'b0, '0, '0, 1'b1, 16'h0010);
        checkOutput("full_ovf",   32'(oOverflow),  32'h1);
        checkOutput("full_stall5", 32'(oCpuStall), 32'h1);
        checkOutput("full_busy",  32'(oWriteIdle), 32'h0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        repeat (8) @(negedge Clock);
        #1;
        checkOutput("full_count", 32'(wrCount - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("full_addr", 32'(logAddr[(base + i) % 64]), 32'(16'h0020 + i));
            checkOutput("full_data", 32'(logData[(base + i) % 64]), 32'(i + 1));
        end
        checkOutput("full_ovf_sticky", 32'(oOverflow),  32'h1);
        checkOutput("full_stall_clr",  32'(oCpuStall),  32'h0);
        checkOutput("full_idle",       32'(oWriteIdle), 32'h1);

        // Starvation: one write queued behind a permanent read stream
        base = wrCount;
        applyStimulus(1'b1, 16'h0040, 3'd6, 1'b1, 16'h0010);
        firstWe = 0;
        weTotal = 0;
        for (int k = 1; k < 100; k++) begin
            @(negedge Clock);
            iCpuWe     = 1'b0;
            validAt[k] = oVgaValid;
            if (oRamWe) begin
                weTotal = weTotal + 1;
                if (firstWe == 0) firstWe = k;
            end
        end
        checkOutput("starve_cycle", 32'(firstWe), 32'd66);
        checkOutput("starve_total", 32'(weTotal), 32'd1);
        checkOutput("starve_addr",  32'(logAddr[base % 64]), 32'h0040);
        checkOutput("starve_data",  32'(logData[base % 64]), 32'h6);
        checkOutput("starve_v65",   32'(validAt[65]), 32'h1);
        checkOutput("starve_v66",   32'(validAt[66]), 32'h1);
        checkOutput("starve_v67",   32'(validAt[67]), 32'h0);
        checkOutput("starve_v68",   32'(validAt[68]), 32'h1);

        // Async reset during a drain with three writes queued
        applyStimulus(1'b1, 16'h0030, 3'd1, 1'b1, 16'h0010);
        applyStimulus(1'b1, 16'h0031, 3'd2, 1'b1, 16'h0010);
        applyStimulus(1'b1, 16'h0032, 3'd3, 1'b1, 16'h0010);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        @(negedge Clock);
        checkOutput("mid_we",   32'(oRamWe),   32'h1);
        checkOutput("mid_addr", 32'(oRamAddr), 32'h0030);
        #2 Reset = 1'b0;
        #1;
        checkOutput("arst_ramAddr",  32'(oRamAddr),   32'h0);
        checkOutput("arst_ramData",  32'(oRamData),   32'h0);
        checkOutput("arst_ramWe",    32'(oRamWe),     32'h0);
        checkOutput("arst_vgaValid", 32'(oVgaValid),  32'h0);
        checkOutput("arst_vgaData",  32'(oVgaData),   32'h0);
        checkOutput("arst_overflow", 32'(oOverflow),  32'h0);
        checkOutput("arst_stall",    32'(oCpuStall),  32'h0);
        checkOutput("arst_idle",     32'(oWriteIdle), 32'h1);
        @(negedge Clock);
        Reset = 1'b1;
        #1 base = wrCount;
        repeat (10) @(negedge Clock);
        #1;
        checkOutput("post_rst_writes", 32'(wrCount - base), 32'd0);
        checkOutput("post_rst_idle",   32'(oWriteIdle),     32'h1);
        checkOutput("post_rst_valid",  32'(oVgaValid),      32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
